freq_lock_ctrl: RTL and testbench

Parametrised digital frequency-lock controller for the on-chip trimmable oscillator. It measures oscillator cycles per high phase of an asynchronous reference, searches a multi-bit trim word by successive approximation, then tracks with ±1 steps. It declares lock after a programmable run of in-window measurements and drops lock after a run of out-of-window ones. It is clocked by the oscillator output and drives the oscillator trim input directly.

---
 rtl/freq_lock_pkg.sv | 22 ++
 rtl/period_meter.sv | 61 ++++++
 rtl/freq_lock_ctrl.sv | 153 +++++++++++++++
 tb/tb_freq_lock_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_lock_pkg.sv
// Shared types and helpers for the oscillator frequency-lock controller.
package freq_lock_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    TRACK  = 2'd2,
    LOCKED = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    TOO_LOW  = 2'd0,
    IN_WIN   = 2'd1,
    TOO_HIGH = 2'd2
  } cls_e;

  // Midscale trim word: only the MSB set.
  function automatic logic [31:0] trim_mid(input int unsigned trim_w);
    return 32'(1) << (trim_w - 1);
  endfunction

endpackage

// File: rtl/period_meter.sv
// Counts clk cycles per synchronised high phase of an asynchronous reference.
module period_meter
  import freq_lock_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             res,
  input  logic             i_ref,
  input  logic             i_disarm,
  output logic [CNT_W-1:0] o_meas,
  output logic             o_meas_valid
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_armed;
  logic [CNT_W-1:0]       r_cnt;
  logic                   w_sync;
  logic                   w_rise;
  logic                   w_fall;

  assign w_sync = r_sync[SYNC_STAGES-1];
  assign w_rise = w_sync & ~r_prev;
  assign w_fall = ~w_sync & r_prev;

  // The rise cycle itself counts, so meas equals the synced high length.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_sync       <= '0;
      r_prev       <= 1'b0;
      r_armed      <= 1'b0;
      r_cnt        <= '0;
      o_meas       <= '0;
      o_meas_valid <= 1'b0;
    end else begin
      r_sync       <= {r_sync[SYNC_STAGES-2:0], i_ref};
      r_prev       <= w_sync;
      o_meas_valid <= 1'b0;

      if (w_rise)
        r_cnt <= CNT_W'(1);
      else if (w_sync && (r_cnt != '1))
        r_cnt <= r_cnt + CNT_W'(1);

      if (i_disarm)
        r_armed <= 1'b0;
      else if (w_rise)
        r_armed <= 1'b1;
      else if (w_fall)
        r_armed <= 1'b0;

      if (w_fall && r_armed && !i_disarm) begin
        o_meas       <= r_cnt;
        o_meas_valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/freq_lock_ctrl.sv
// Frequency-lock controller: SAR trim search, +/-1 tracking, lock/unlock hysteresis.
module freq_lock_ctrl
  import freq_lock_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned TRIM_W      = 6,
  parameter int unsigned TOL_W       = 8,
  parameter int unsigned LOCK_CNT    = 4,
  parameter int unsigned UNLOCK_CNT  = 2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              res,
  input  logic              enable,
  input  logic              ref_in,
  input  logic [CNT_W-1:0]  target,
  input  logic [TOL_W-1:0]  tol,
  output logic [TRIM_W-1:0] trim,
  output logic              lock,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  meas,
  output logic              meas_valid
);

  localparam int unsigned EXT_W  = CNT_W + 1;
  localparam int unsigned IDX_W  = $clog2(TRIM_W);
  localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int unsigned BAD_W  = $clog2(UNLOCK_CNT + 1);
  localparam logic [TRIM_W-1:0] TRIM_MID = TRIM_W'(trim_mid(TRIM_W));
  localparam logic [IDX_W-1:0]  IDX_TOP  = IDX_W'(TRIM_W - 1);

  state_e              r_state;
  logic [TRIM_W-1:0]   r_trim;
  logic [IDX_W-1:0]    r_idx;
  logic                r_lock;
  logic [GOOD_W-1:0]   r_good;
  logic [BAD_W-1:0]    r_bad;
  logic [CNT_W-1:0]    w_meas;
  logic                w_meas_valid;
  logic                w_disarm;
  logic [EXT_W-1:0]    w_meas_x;
  logic [EXT_W-1:0]    w_tgt_x;
  logic [EXT_W-1:0]    w_tol_x;
  cls_e                w_cls;

  assign w_disarm = (r_state == IDLE) | ~enable;

  period_meter #(
    .CNT_W       (CNT_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_meter (
    .clk          (clk),
    .res          (res),
    .i_ref        (ref_in),
    .i_disarm     (w_disarm),
    .o_meas       (w_meas),
    .o_meas_valid (w_meas_valid)
  );

  assign w_meas_x = EXT_W'(w_meas);
  assign w_tgt_x  = EXT_W'(target);
  assign w_tol_x  = EXT_W'(tol);

  // One extra bit keeps target+tol and meas+tol from wrapping.
  always_comb begin
    w_cls = IN_WIN;
    if ((w_meas == '1) || (w_meas_x > (w_tgt_x + w_tol_x)))
      w_cls = TOO_HIGH;
    else if ((w_meas_x + w_tol_x) < w_tgt_x)
      w_cls = TOO_LOW;
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_state <= IDLE;
      r_trim  <= TRIM_MID;
      r_idx   <= IDX_TOP;
      r_lock  <= 1'b0;
      r_good  <= '0;
      r_bad   <= '0;
    end else if (!enable) begin
      r_state <= IDLE;
      r_lock  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state <= SEARCH;
          r_trim  <= TRIM_MID;
          r_idx   <= IDX_TOP;
          r_good  <= '0;
          r_bad   <= '0;
        end
        SEARCH: if (w_meas_valid) begin
          if (w_cls == IN_WIN) begin
            r_state <= TRACK;
            r_good  <= GOOD_W'(1);
          end else begin
            if (w_cls == TOO_HIGH)
              r_trim[r_idx] <= 1'b0;
            if (r_idx != '0) begin
              r_trim[r_idx - IDX_W'(1)] <= 1'b1;
              r_idx                     <= r_idx - IDX_W'(1);
            end else begin
              r_state <= TRACK;
              r_good  <= '0;
            end
          end
        end
        TRACK: if (w_meas_valid) begin
          case (w_cls)
            TOO_HIGH: begin
              if (r_trim != '0) r_trim <= r_trim - TRIM_W'(1);
              r_good <= '0;
            end
            TOO_LOW: begin
              if (r_trim != '1) r_trim <= r_trim + TRIM_W'(1);
              r_good <= '0;
            end
            default: begin
              if (r_good >= GOOD_W'(LOCK_CNT - 1)) begin
                r_state <= LOCKED;
                r_lock  <= 1'b1;
                r_bad   <= '0;
              end else begin
                r_good <= r_good + GOOD_W'(1);
              end
            end
          endcase
        end
        LOCKED: if (w_meas_valid) begin
          if (w_cls == IN_WIN) begin
            r_bad <= '0;
          end else if (r_bad >= BAD_W'(UNLOCK_CNT - 1)) begin
            r_state <= TRACK;
            r_lock  <= 1'b0;
            r_good  <= '0;
            r_bad   <= '0;
          end else begin
            r_bad <= r_bad + BAD_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign trim       = r_trim;
  assign lock       = r_lock;
  assign state      = r_state;
  assign meas       = w_meas;
  assign meas_valid = w_meas_valid;

endmodule

// File: tb/tb_freq_lock_ctrl.sv
// Directed bench for freq_lock_ctrl: oscillator model count = k * trim.
module tb_freq_lock_ctrl;

  logic        clk;
  logic        res;
  logic        enable;
  logic        ref_in;
  logic [15:0] target;
  logic [7:0]  tol;
  logic [5:0]  trim;
  logic        lock;
  logic [1:0]  state;
  logic [15:0] meas;
  logic        meas_valid;

  int n_tests;
  int n_fail;
  int mv_cnt;
  int last_meas;

  freq_lock_ctrl #(
    .CNT_W       (16),
    .TRIM_W      (6),
    .TOL_W       (8),
    .LOCK_CNT    (4),
    .UNLOCK_CNT  (2),
    .SYNC_STAGES (2)
  ) dut (
    .clk        (clk),
    .res        (res),
    .enable     (enable),
    .ref_in     (ref_in),
    .target     (target),
    .tol        (tol),
    .trim       (trim),
    .lock       (lock),
    .state      (state),
    .meas       (meas),
    .meas_valid (meas_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (meas_valid === 1'b1) begin
      mv_cnt    = mv_cnt + 1;
      last_meas = int'(meas);
    end
  end

  task automatic ref_pulse(input int hi, input int lo);
    @(negedge clk);
    ref_in = 1'b1;
    repeat (hi) @(negedge clk);
    ref_in = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic model_pulse(input int k);
    ref_pulse(k * int'(trim), 12);
  endtask

  task automatic test_reset;
    @(negedge clk);
    if (trim !== 6'd32) begin n_fail++; $display("FAIL rst_trim: got %0d expected 32", trim); end
    n_tests++;
    if (lock !== 1'b0) begin n_fail++; $display("FAIL rst_lock: got %0b expected 0", lock); end
    n_tests++;
    if (state !== 2'd0) begin n_fail++; $display("FAIL rst_state: got %0d expected 0", state); end
    n_tests++;
    if (meas !== 16'd0 || meas_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_meas: got %0d/%0b expected 0/0", meas, meas_valid);
    end
    n_tests++;
    res = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_acquisition;
    int exp_trim[5];
    int exp_st[5];
    exp_trim = '{16, 24, 28, 26, 26};
    exp_st   = '{1, 1, 1, 1, 2};
    target = 16'd255;
    tol    = 8'd5;
    enable = 1'b1;
    @(negedge clk);
    if (state !== 2'd1 || trim !== 6'd32) begin
      n_fail++; $display("FAIL acq_start: got st=%0d trim=%0d expected st=1 trim=32", state, trim);
    end
    n_tests++;
    for (int i = 0; i < 5; i++) begin
      model_pulse(10);
      if (trim !== 6'(exp_trim[i]) || state !== 2'(exp_st[i])) begin
        n_fail++;
        $display("FAIL acq_step%0d: got trim=%0d st=%0d expected trim=%0d st=%0d",
                 i, trim, state, exp_trim[i], exp_st[i]);
      end
      n_tests++;
    end
    if (last_meas != 260) begin n_fail++; $display("FAIL acq_meas: got %0d expected 260", last_meas); end
    n_tests++;
    for (int i = 0; i < 3; i++) begin
      model_pulse(10);
      if (lock !== (i == 2) || state !== ((i == 2) ? 2'd3 : 2'd2)) begin
        n_fail++;
        $display("FAIL acq_lock%0d: got lock=%0b st=%0d expected lock=%0b", i, lock, state, (i == 2));
      end
      n_tests++;
    end
    if (trim !== 6'd26) begin n_fail++; $display("FAIL acq_final_trim: got %0d expected 26", trim); end
    n_tests++;
  endtask

  task automatic test_loss_of_lock;
    model_pulse(8);
    if (lock !== 1'b1 || state !== 2'd3 || trim !== 6'd26) begin
      n_fail++; $display("FAIL loss_bad1: got lock=%0b st=%0d trim=%0d expected 1/3/26", lock, state, trim);
    end
    n_tests++;
    model_pulse(8);
    if (lock !== 1'b0 || state !== 2'd2 || trim !== 6'd26) begin
      n_fail++; $display("FAIL loss_bad2: got lock=%0b st=%0d trim=%0d expected 0/2/26", lock, state, trim);
    end
    n_tests++;
    for (int i = 0; i < 6; i++) begin
      model_pulse(8);
      if (trim !== 6'(27 + i) || state !== 2'd2) begin
        n_fail++; $display("FAIL loss_step%0d: got trim=%0d st=%0d expected trim=%0d st=2", i, trim, state, 27 + i);
      end
      n_tests++;
    end
    for (int i = 0; i < 4; i++) begin
      model_pulse(8);
      if (lock !== (i == 3) || trim !== 6'd32) begin
        n_fail++; $display("FAIL relock%0d: got lock=%0b trim=%0d expected lock=%0b trim=32", i, lock, trim, (i == 3));
      end
      n_tests++;
    end
    if (state !== 2'd3) begin n_fail++; $display("FAIL relock_state: got %0d expected 3", state); end
    n_tests++;
  endtask

  task automatic test_enable_drop;
    enable = 1'b0;
    @(negedge clk);
    if (state !== 2'd0 || lock !== 1'b0 || trim !== 6'd32) begin
      n_fail++; $display("FAIL en_drop: got st=%0d lock=%0b trim=%0d expected 0/0/32", state, lock, trim);
    end
    n_tests++;
    repeat (5) @(negedge clk);
    if (trim !== 6'd32 || state !== 2'd0) begin
      n_fail++; $display("FAIL en_hold: got trim=%0d st=%0d expected 32/0", trim, state);
    end
    n_tests++;
  endtask

  task automatic test_saturation;
    int exp_trim[6];
    exp_trim = '{16, 8, 4, 2, 1, 0};
    target = 16'd0;
    tol    = 8'd0;
    enable = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      ref_pulse(10, 12);
      if (trim !== 6'(exp_trim[i])) begin
        n_fail++; $display("FAIL sat_search%0d: got %0d expected %0d", i, trim, exp_trim[i]);
      end
      n_tests++;
    end
    if (state !== 2'd2) begin n_fail++; $display("FAIL sat_track: got %0d expected 2", state); end
    n_tests++;
    ref_pulse(10, 12);
    if (trim !== 6'd0) begin n_fail++; $display("FAIL sat_trim_floor: got %0d expected 0", trim); end
    n_tests++;
    target = 16'hFFFF;
    ref_pulse(10, 12);
    ref_pulse(10, 12);
    if (trim !== 6'd2) begin n_fail++; $display("FAIL sat_up: got %0d expected 2", trim); end
    n_tests++;
    ref_pulse(70000, 12);
    if (last_meas != 65535) begin n_fail++; $display("FAIL sat_meas: got %0d expected 65535", last_meas); end
    n_tests++;
    if (trim !== 6'd1 || state !== 2'd2) begin
      n_fail++; $display("FAIL sat_dec: got trim=%0d st=%0d expected 1/2", trim, state);
    end
    n_tests++;
  endtask

  task automatic test_partial_phase;
    int mv0;
    @(negedge clk);
    res    = 1'b1;
    enable = 1'b0;
    target = 16'd255;
    tol    = 8'd5;
    @(negedge clk);
    res    = 1'b0;
    ref_in = 1'b1;
    repeat (20) @(negedge clk);
    enable = 1'b1;
    mv0 = mv_cnt;
    repeat (30) @(negedge clk);
    ref_in = 1'b0;
    repeat (12) @(negedge clk);
    if (mv_cnt != mv0) begin n_fail++; $display("FAIL partial_mv: got %0d strobes expected 0", mv_cnt - mv0); end
    n_tests++;
    if (trim !== 6'd32 || state !== 2'd1) begin
      n_fail++; $display("FAIL partial_hold: got trim=%0d st=%0d expected 32/1", trim, state);
    end
    n_tests++;
    ref_pulse(50, 12);
    if (mv_cnt != mv0 + 1 || last_meas != 50) begin
      n_fail++; $display("FAIL partial_full: got strobes=%0d meas=%0d expected 1/50", mv_cnt - mv0, last_meas);
    end
    n_tests++;
    if (trim !== 6'd48) begin n_fail++; $display("FAIL partial_trim: got %0d expected 48", trim); end
    n_tests++;
  endtask

  task automatic test_reset_mid_search;
    @(negedge clk);
    res = 1'b1;
    #1;
    if (trim !== 6'd32 || lock !== 1'b0 || state !== 2'd0 || meas !== 16'd0) begin
      n_fail++;
      $display("FAIL async_rst: got trim=%0d lock=%0b st=%0d meas=%0d expected 32/0/0/0", trim, lock, state, meas);
    end
    n_tests++;
    @(negedge clk);
    res = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    mv_cnt    = 0;
    last_meas = 0;
    res       = 1'b1;
    enable    = 1'b0;
    ref_in    = 1'b0;
    target    = 16'd255;
    tol       = 8'd5;
    test_reset();
    test_acquisition();
    test_loss_of_lock();
    test_enable_drop();
    test_saturation();
    test_partial_phase();
    test_reset_mid_search();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
